// File: rtl/anita_trigger_buffer_manager.sv
// Trigger acceptance and round-robin hold-buffer manager for the TURF trigger path.
// Edge-detects enabled sources, holds a free buffer, issues a tagged digitize pulse, then enforces holdoff.
module anita_trigger_buffer_manager #(
    parameter int NUM_SRC   = 4,
    parameter int NUM_BUF   = 4,
    parameter int BUF_W     = 2,
    parameter int HOLD_DLY  = 4,
    parameter int HOLDOFF_W = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk250_i,
    input  logic                 rst_n_i,
    input  logic [NUM_SRC-1:0]   trig_i,
    input  logic [NUM_SRC-1:0]   src_en_i,
    input  logic [HOLDOFF_W-1:0] holdoff_i,
    input  logic                 clear_i,
    input  logic [BUF_W-1:0]     clear_buffer_i,
    output logic                 digitize_o,
    output logic [BUF_W-1:0]     digitize_buffer_o,
    output logic [NUM_SRC-1:0]   digitize_source_o,
    output logic [NUM_BUF-1:0]   buffer_status_o,
    output logic [NUM_BUF-1:0]   HOLD_o,
    output logic                 dead_o,
    output logic [CNT_W-1:0]     trig_count_o,
    output logic [CNT_W-1:0]     lost_count_o
);
    localparam int CW = (HOLDOFF_W > 8) ? HOLDOFF_W : 8;

    typedef enum logic [1:0] {IDLE, ARM, DIGI, HOLDOFF} state_t;

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   trig_q, trig_qq;
    logic [NUM_SRC-1:0]   edge_q, edge_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BUF_W-1:0]     ptr_q, ptr_d;
    logic [NUM_BUF-1:0]   status_q, status_d;
    logic                 digitize_q, digitize_d;
    logic [BUF_W-1:0]     dig_buf_q, dig_buf_d;
    logic [NUM_SRC-1:0]   dig_src_q, dig_src_d;
    logic                 dead_q, dead_d;
    logic [CNT_W-1:0]     trig_cnt_q, trig_cnt_d;
    logic [CNT_W-1:0]     lost_cnt_q, lost_cnt_d;

    logic                 trig_fire;
    logic                 full;
    logic                 found;
    logic [BUF_W-1:0]     idx;
    logic [BUF_W-1:0]     free_idx;

    always_comb begin
        edge_d    = trig_q & ~trig_qq & src_en_i;
        trig_fire = |edge_q;
        full      = &status_q;

        // Round-robin search for the first free buffer starting at the pointer.
        found    = 1'b0;
        idx      = ptr_q;
        free_idx = ptr_q;
        for (int i = 0; i < NUM_BUF; i++) begin
            idx = ptr_q + BUF_W'(i);
            if (!found && !status_q[idx]) begin
                found    = 1'b1;
                free_idx = idx;
            end
        end

        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        dig_buf_d  = dig_buf_q;
        dig_src_d  = dig_src_q;
        trig_cnt_d = trig_cnt_q;
        lost_cnt_d = lost_cnt_q;

        status_d = status_q;
        if (clear_i) status_d[clear_buffer_i] = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig_fire && !full) begin
                    dig_buf_d          = free_idx;
                    dig_src_d          = edge_q;
                    status_d[free_idx] = 1'b1;
                    cnt_d              = CW'(HOLD_DLY - 1);
                    ptr_d              = free_idx + BUF_W'(1);
                    state_d            = ARM;
                end
            end
            ARM: begin
                if (cnt_q == '0) state_d = DIGI;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DIGI: begin
                if (holdoff_i == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CW'(holdoff_i - HOLDOFF_W'(1));
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Status is only seen one cycle late, so a same-cycle clear cannot rescue a full trigger.
        if (trig_fire && !(state_q == IDLE && !full) && (lost_cnt_q != '1))
            lost_cnt_d = lost_cnt_q + 1'b1;

        digitize_d = (state_d == DIGI);
        if (digitize_d) trig_cnt_d = trig_cnt_q + 1'b1;

        dead_d = (state_d != IDLE) | (&status_d);
    end

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            trig_q     <= '1;
            trig_qq    <= '1;
            edge_q     <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            status_q   <= '0;
            digitize_q <= 1'b0;
            dig_buf_q  <= '0;
            dig_src_q  <= '0;
            dead_q     <= 1'b0;
            trig_cnt_q <= '0;
            lost_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trig_i;
            trig_qq    <= trig_q;
            edge_q     <= edge_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            status_q   <= status_d;
            digitize_q <= digitize_d;
            dig_buf_q  <= dig_buf_d;
            dig_src_q  <= dig_src_d;
            dead_q     <= dead_d;
            trig_cnt_q <= trig_cnt_d;
            lost_cnt_q <= lost_cnt_d;
        end
    end

    assign digitize_o        = digitize_q;
    assign digitize_buffer_o = dig_buf_q;
    assign digitize_source_o = dig_src_q;
    assign buffer_status_o   = status_q;
    assign HOLD_o            = status_q;
    assign dead_o            = dead_q;
    assign trig_count_o      = trig_cnt_q;
    assign lost_count_o      = lost_cnt_q;

endmodule

// File: tb/tb_anita_trigger_buffer_manager.sv
// Scoreboard bench for anita_trigger_buffer_manager: expected digitize tags are queued at stimulus time.
module tb_anita_trigger_buffer_manager;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] trig = '0;
    logic [3:0] src_en = '0;
    logic [7:0] holdoff = '0;
    logic       clear = 1'b0;
    logic [1:0] clear_buf = '0;
    logic       digitize;
    logic [1:0] dig_buf;
    logic [3:0] dig_src;
    logic [3:0] status;
    logic [3:0] hold;
    logic       dead;
    logic [15:0] trig_cnt;
    logic [15:0] lost_cnt;

    typedef struct packed {
        logic [1:0] b;
        logic [3:0] s;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    anita_trigger_buffer_manager #(
        .NUM_SRC(4), .NUM_BUF(4), .BUF_W(2), .HOLD_DLY(4), .HOLDOFF_W(8), .CNT_W(16)
    ) dut (
        .clk250_i(clk), .rst_n_i(rst_n), .trig_i(trig), .src_en_i(src_en),
        .holdoff_i(holdoff), .clear_i(clear), .clear_buffer_i(clear_buf),
        .digitize_o(digitize), .digitize_buffer_o(dig_buf), .digitize_source_o(dig_src),
        .buffer_status_o(status), .HOLD_o(hold), .dead_o(dead),
        .trig_count_o(trig_cnt), .lost_count_o(lost_cnt)
    );

    always #2 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && digitize) begin
            exp_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_digitize: got buf=%0d src=%b, none expected", dig_buf, dig_src);
            end else begin
                e = exp_q.pop_front();
                if ({dig_buf, dig_src} !== {e.b, e.s}) begin
                    n_fail++;
                    $display("FAIL digitize_tag: got buf=%0d src=%b, expected buf=%0d src=%b",
                             dig_buf, dig_src, e.b, e.s);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] m);
        trig = m;
        tick(1);
        trig = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        trig  = '0;
        clear = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        n_checks++;
        if ({digitize, dig_buf, dig_src, status, hold, dead, trig_cnt, lost_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dig=%b buf=%0d src=%b st=%b hold=%b dead=%b tc=%0d lc=%0d, expected all 0",
                     digitize, dig_buf, dig_src, status, hold, dead, trig_cnt, lost_cnt);
        end
        rst_n = 1'b1;
        tick(3);
        n_checks++;
        if ({status, dead, trig_cnt} !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got st=%b dead=%b tc=%0d, expected 0", status, dead, trig_cnt);
        end
    endtask

    task automatic test_single_rf();
        apply_reset();
        src_en = 4'b0001;
        holdoff = 8'd0;
        exp_q.push_back('{b: 2'd0, s: 4'b0001});
        pulse(4'b0001);
        tick(1);
        n_checks++;
        if (hold !== 4'b0000) begin
            n_fail++;
            $display("FAIL hold_early: got %b, expected 0000", hold);
        end
        tick(1);
        n_checks++;
        if ({hold, status, dead, dig_buf} !== {4'b0001, 4'b0001, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL hold_latency: got hold=%b st=%b dead=%b buf=%0d, expected 0001 0001 1 0",
                     hold, status, dead, dig_buf);
        end
        tick(3);
        n_checks++;
        if (digitize !== 1'b0) begin
            n_fail++;
            $display("FAIL digitize_early: got %b, expected 0", digitize);
        end
        tick(1);
        n_checks++;
        if (digitize !== 1'b1) begin
            n_fail++;
            $display("FAIL digitize_latency: got %b, expected 1", digitize);
        end
        tick(1);
        n_checks++;
        if ({digitize, trig_cnt, dead, hold} !== {1'b0, 16'd1, 1'b0, 4'b0001}) begin
            n_fail++;
            $display("FAIL after_digitize: got dig=%b tc=%0d dead=%b hold=%b, expected 0 1 0 0001",
                     digitize, trig_cnt, dead, hold);
        end
    endtask

    task automatic test_fill();
        apply_reset();
        src_en = 4'b1111;
        holdoff = 8'd0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{b: 2'(i), s: 4'b1000});
            pulse(4'b1000);
            tick(20);
        end
        n_checks++;
        if ({status, hold, dead, trig_cnt} !== {4'b1111, 4'b1111, 1'b1, 16'd4}) begin
            n_fail++;
            $display("FAIL fill: got st=%b hold=%b dead=%b tc=%0d, expected 1111 1111 1 4",
                     status, hold, dead, trig_cnt);
        end
        pulse(4'b1000);
        tick(20);
        n_checks++;
        if ({lost_cnt, trig_cnt, status} !== {16'd1, 16'd4, 4'b1111}) begin
            n_fail++;
            $display("FAIL full_lost: got lc=%0d tc=%0d st=%b, expected 1 4 1111", lost_cnt, trig_cnt, status);
        end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        clear_buf = 2'd2;
        tick(1);
        clear = 1'b0;
        n_checks++;
        if ({status, hold, dead} !== {4'b1011, 4'b1011, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_one: got st=%b hold=%b dead=%b, expected 1011 1011 0", status, hold, dead);
        end
        exp_q.push_back('{b: 2'd2, s: 4'b1000});
        pulse(4'b1000);
        tick(15);
        n_checks++;
        if ({status, dig_buf} !== {4'b1111, 2'd2}) begin
            n_fail++;
            $display("FAIL realloc: got st=%b buf=%0d, expected 1111 2", status, dig_buf);
        end
        clear = 1'b1;
        clear_buf = 2'd0;
        tick(1);
        clear_buf = 2'd3;
        tick(1);
        clear = 1'b0;
        n_checks++;
        if (status !== 4'b0110) begin
            n_fail++;
            $display("FAIL clear_two: got st=%b, expected 0110", status);
        end
        exp_q.push_back('{b: 2'd3, s: 4'b1000});
        pulse(4'b1000);
        tick(15);
        n_checks++;
        if ({status, dig_buf} !== {4'b1110, 2'd3}) begin
            n_fail++;
            $display("FAIL pointer_search: got st=%b buf=%0d, expected 1110 3", status, dig_buf);
        end
        exp_q.push_back('{b: 2'd0, s: 4'b1000});
        pulse(4'b1000);
        tick(15);
        n_checks++;
        if ({status, dig_buf, trig_cnt, lost_cnt} !== {4'b1111, 2'd0, 16'd7, 16'd1}) begin
            n_fail++;
            $display("FAIL pointer_wrap: got st=%b buf=%0d tc=%0d lc=%0d, expected 1111 0 7 1",
                     status, dig_buf, trig_cnt, lost_cnt);
        end
    endtask

    task automatic test_holdoff();
        bit seen;
        apply_reset();
        src_en = 4'b0001;
        holdoff = 8'd10;
        exp_q.push_back('{b: 2'd0, s: 4'b0001});
        pulse(4'b0001);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1);
            if (digitize) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL holdoff_first_digitize: got no pulse in 40 cycles, expected one");
        end
        tick(5);
        pulse(4'b0001);
        tick(4);
        n_checks++;
        if (dead !== 1'b1) begin
            n_fail++;
            $display("FAIL holdoff_dead: got %b, expected 1", dead);
        end
        tick(1);
        n_checks++;
        if ({dead, lost_cnt, trig_cnt} !== {1'b0, 16'd1, 16'd1}) begin
            n_fail++;
            $display("FAIL holdoff_end: got dead=%b lc=%0d tc=%0d, expected 0 1 1", dead, lost_cnt, trig_cnt);
        end
        tick(1);
        exp_q.push_back('{b: 2'd1, s: 4'b0001});
        pulse(4'b0001);
        tick(30);
        n_checks++;
        if ({trig_cnt, lost_cnt, status} !== {16'd2, 16'd1, 4'b0011}) begin
            n_fail++;
            $display("FAIL holdoff_accept: got tc=%0d lc=%0d st=%b, expected 2 1 0011", trig_cnt, lost_cnt, status);
        end
        holdoff = 8'd0;
    endtask

    task automatic test_multi_src();
        apply_reset();
        src_en = 4'b1111;
        exp_q.push_back('{b: 2'd0, s: 4'b1010});
        pulse(4'b1010);
        tick(12);
        n_checks++;
        if ({trig_cnt, dig_src, lost_cnt} !== {16'd1, 4'b1010, 16'd0}) begin
            n_fail++;
            $display("FAIL multi_src: got tc=%0d src=%b lc=%0d, expected 1 1010 0", trig_cnt, dig_src, lost_cnt);
        end
        src_en = 4'b1011;
        pulse(4'b0100);
        tick(12);
        n_checks++;
        if ({trig_cnt, lost_cnt, status} !== {16'd1, 16'd0, 4'b0001}) begin
            n_fail++;
            $display("FAIL disabled_src: got tc=%0d lc=%0d st=%b, expected 1 0 0001", trig_cnt, lost_cnt, status);
        end
    endtask

    task automatic test_reset_behaviour();
        src_en = 4'b1111;
        rst_n = 1'b0;
        trig = 4'b0001;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        trig = '0;
        tick(4);
        n_checks++;
        if ({trig_cnt, lost_cnt, status} !== {16'd0, 16'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL level_at_reset: got tc=%0d lc=%0d st=%b, expected 0 0 0000", trig_cnt, lost_cnt, status);
        end
        pulse(4'b0001);
        tick(2);
        n_checks++;
        if (hold !== 4'b0001) begin
            n_fail++;
            $display("FAIL arm_hold: got %b, expected 0001", hold);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({hold, status, dead} !== {4'b0000, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got hold=%b st=%b dead=%b, expected 0000 0000 0", hold, status, dead);
        end
        tick(2);
        rst_n = 1'b1;
        tick(15);
        n_checks++;
        if ({hold, trig_cnt, lost_cnt} !== {4'b0000, 16'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL abandoned_seq: got hold=%b tc=%0d lc=%0d, expected 0000 0 0", hold, trig_cnt, lost_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_rf();
        test_fill();
        test_clear();
        test_holdoff();
        test_multi_src();
        test_reset_behaviour();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending digitize tags, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/anita_trigger_buffer_manager.md
Name: anita_trigger_buffer_manager

Overview:
Parametrised successor to the fixed four-source, four-buffer trigger and buffer manager in the TURF trigger interface. It accepts NUM_SRC edge-detected trigger sources with per-source enables and allocates NUM_BUF SURF hold buffers round-robin. For each accepted trigger it asserts the buffer HOLD, waits a settle delay, then issues a digitize pulse tagged with buffer and source, and finally enforces a programmable holdoff. It also keeps accepted and lost trigger counters for the scaler and event path.

Parameters:
NUM_SRC, 4, number of trigger sources (bit 0 RF, 1 PPS1, 2 PPS2, 3 soft)
NUM_BUF, 4, number of hold buffers (power of two, 2..16)
BUF_W, 2, log2(NUM_BUF)
HOLD_DLY, 4, cycles HOLD is asserted before digitize_o (1..255)
HOLDOFF_W, 8, width of holdoff_i
CNT_W, 16, width of trigger and lost counters

Ports:
clk250_i  in  1  250 MHz system clock; all logic on rising edge
rst_n_i  in  1  asynchronous active-low reset
trig_i  in  NUM_SRC  trigger sources, rising-edge detected
src_en_i  in  NUM_SRC  per-source enable; disabled sources are ignored entirely
holdoff_i  in  HOLDOFF_W  minimum dead cycles after each digitize pulse
clear_i  in  1  one-cycle pulse; releases the buffer on clear_buffer_i
clear_buffer_i  in  BUF_W  buffer index to release
digitize_o  out  1  one-cycle digitize command
digitize_buffer_o  out  BUF_W  buffer being digitized; held until next digitize
digitize_source_o  out  NUM_SRC  mask of enabled sources whose edges caused the trigger; held
buffer_status_o  out  NUM_BUF  1 = buffer occupied
HOLD_o  out  NUM_BUF  per-buffer hold to the SURFs
dead_o  out  1  trigger cannot be accepted this cycle
trig_count_o  out  CNT_W  accepted triggers; wraps
lost_count_o  out  CNT_W  triggers rejected while dead; saturates at all-ones

Behaviour:
- Reset (async, rst_n_i low): all outputs 0, state IDLE, next pointer 0, and the trig_i history registers are set to all-ones so that a level already high at reset release does not fire.
- Edge detect: trig_q <= trig_i and trig_qq <= trig_q. edge = trig_q & ~trig_qq & src_en_i. Any edge bit set means "trigger".
- Free search: starting at the next pointer and wrapping, select the first buffer with status 0. full = &buffer_status_o.
- dead_o = (state != IDLE) | full, registered from next-state and next-status. dead_o is 0 only when the next trigger would be accepted.
- FSM states and transitions:
  - IDLE: on trigger and not full, latch the free buffer into digitize_buffer_o and edge into digitize_source_o. Set status[b] and HOLD_o[b], load delay counter = HOLD_DLY-1, set next pointer = b+1 (mod NUM_BUF), go to ARM.
  - ARM: count down; at 0, go to DIGI.
  - DIGI: digitize_o = 1 for exactly this cycle, trig_count_o += 1. If holdoff_i == 0, go to IDLE; else load holdoff_i-1 and go to HOLDOFF. holdoff_i is sampled only here.
  - HOLDOFF: count down; at 0, go to IDLE.
- Latency: trig_i rising, sampled at edge k, gives HOLD_o high after edge k+2 and digitize_o high after edge k+2+HOLD_DLY.
- Lost triggers: a trigger edge seen in any state other than IDLE, or in IDLE while full, increments lost_count_o by 1 per cycle regardless of how many bits are set. No buffer state changes.
- Clear: on clear_i, status[clear_buffer_i] and HOLD_o[clear_buffer_i] drop to 0 at the next edge. Clearing an unoccupied buffer is a no-op. Clearing the buffer currently in ARM/DIGI/HOLDOFF also releases it; the FSM still completes its sequence (digitize_o is still issued).
- Simultaneous clear and trigger while full: the trigger is lost, because status is updated one cycle later. Simultaneous clear of buffer X and allocation of buffer Y != X: both take effect.
- Simultaneous edges on several sources: one trigger, and digitize_source_o carries all of the bits.
- Reset mid-sequence: everything clears immediately, and any in-flight digitize is abandoned.

Test Plan:
- Single RF edge with src_en=4'b0001, HOLD_DLY=4, holdoff=0 -> HOLD_o=0001 two cycles after sampling, digitize_o one pulse 4 cycles later, buffer 0, source 0001, trig_count=1.
- Four soft triggers spaced 20 cycles with no clears -> buffers 0,1,2,3 allocated, buffer_status=1111, dead_o=1. A fifth trigger gives lost_count=1, no digitize.
- With full buffers, clear buffer 2 -> status=1011 next cycle. The next trigger allocates buffer 2, and the pointer then searches from 3.
- holdoff_i=10: a second edge 5 cycles after digitize is lost (lost_count+1). An edge 12 cycles after digitize is accepted.
- Edges on sources 1 and 3 in the same cycle with src_en=1111 -> one digitize, source=1010. Source 2 edge with src_en[2]=0 -> no digitize, no lost count.
- trig_i held high through rst_n_i release -> no trigger. Reset asserted during ARM -> HOLD_o=0, digitize_o never pulses, counters 0.
